// File: rtl/div_pkg.sv
// Shared constants, state codes and bus widths for the multi-cycle divider.
package div_pkg;

    localparam logic RST_ENABLE  = 1'b1;
    localparam logic STOP        = 1'b1;
    localparam logic NO_STOP     = 1'b0;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    localparam int unsigned REG_BUS        = 32;
    localparam int unsigned DOUBLE_REG_BUS = 64;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_t;

endpackage

// File: rtl/div.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per clock,
// result {remainder, quotient} held until the requester drops start_i.
module div
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = REG_BUS,
    parameter int unsigned CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    div_state_t         state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [WIDTH-1:0]   dvd, dvd_d;
    logic [WIDTH-1:0]   rem, rem_d;
    logic [WIDTH-1:0]   dvs, dvs_d;
    logic               q_neg, q_neg_d;
    logic               r_neg, r_neg_d;
    logic [2*WIDTH-1:0] result_d;
    logic               ready_d;

    logic               op1_neg, op2_neg;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     r_sh, diff;
    logic [WIDTH-1:0]   quot_f, rem_f;

    // Operand magnitudes, one restoring step and final sign fix-up.
    always_comb begin
        op1_neg = signed_div_i & opdata1_i[WIDTH-1];
        op2_neg = signed_div_i & opdata2_i[WIDTH-1];
        mag1    = op1_neg ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
        mag2    = op2_neg ? (~opdata2_i + WIDTH'(1)) : opdata2_i;
        // Compare one bit wider than the operands so all-ones divisors cannot wrap.
        r_sh    = {rem, dvd[WIDTH-1]};
        diff    = r_sh - {1'b0, dvs};
        quot_f  = q_neg ? (~dvd + WIDTH'(1)) : dvd;
        rem_f   = r_neg ? (~rem + WIDTH'(1)) : rem;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        dvd_d    = dvd;
        rem_d    = rem;
        dvs_d    = dvs;
        q_neg_d  = q_neg;
        r_neg_d  = r_neg;
        result_d = result_o;
        ready_d  = ready_o;

        unique case (state)
            DIV_FREE: begin
                result_d = '0;
                ready_d  = DIV_RESULT_NOT_READY;
                if (start_i == DIV_START && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = DIV_BYZERO;
                    end else begin
                        state_d = DIV_ON;
                        cnt_d   = '0;
                        dvd_d   = mag1;
                        rem_d   = '0;
                        dvs_d   = mag2;
                        q_neg_d = op1_neg ^ op2_neg;
                        r_neg_d = op1_neg;
                    end
                end
            end
            DIV_BYZERO: begin
                if (annul_i) begin
                    state_d  = DIV_FREE;
                    result_d = '0;
                    ready_d  = DIV_RESULT_NOT_READY;
                end else begin
                    state_d  = DIV_END;
                    result_d = '0;
                    ready_d  = DIV_RESULT_READY;
                end
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_d  = DIV_FREE;
                    cnt_d    = '0;
                    result_d = '0;
                    ready_d  = DIV_RESULT_NOT_READY;
                end else if (cnt == CNT_W'(WIDTH)) begin
                    state_d  = DIV_END;
                    cnt_d    = '0;
                    result_d = {rem_f, quot_f};
                    ready_d  = DIV_RESULT_READY;
                end else begin
                    // The dividend register fills with quotient bits from the bottom.
                    if (!diff[WIDTH]) begin
                        rem_d = diff[WIDTH-1:0];
                        dvd_d = {dvd[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = r_sh[WIDTH-1:0];
                        dvd_d = {dvd[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            DIV_END: begin
                if (annul_i || start_i == DIV_STOP) begin
                    state_d  = DIV_FREE;
                    result_d = '0;
                    ready_d  = DIV_RESULT_NOT_READY;
                end
            end
            default: state_d = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state    <= DIV_FREE;
            cnt      <= '0;
            dvd      <= '0;
            rem      <= '0;
            dvs      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            dvd      <= dvd_d;
            rem      <= rem_d;
            dvs      <= dvs_d;
            q_neg    <= q_neg_d;
            r_neg    <= r_neg_d;
            result_o <= result_d;
            ready_o  <= ready_d;
        end
    end

endmodule

// File: tb/tb_div.sv
// Directed bench for div: vector table plus annul and mid-operation reset sequences.
module tb_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i, opdata2_i;
    logic        start_i, annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_checks = 0;
    int n_fail   = 0;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Counts edges from the start edge E0 until ready_o is seen; -1 on timeout.
    task automatic wait_ready(output int lat);
        int edges = 0;
        lat = -1;
        while (edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (ready_o) begin
                lat = edges - 1;
                break;
            end
        end
    endtask

    task automatic release_and_check(input string name);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk); #1;
        check({name, " drop ready"}, 64'(ready_o), 64'd0);
        check({name, " drop result"}, result_o, 64'd0);
    endtask

    task automatic run_op(input string name, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_res);
        int lat;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(posedge clk);
        // Scramble operands after the start edge; they must be ignored.
        @(negedge clk);
        opdata1_i = 32'h5A5A_1234;
        opdata2_i = 32'h0000_0000;
        signed_div_i = ~sgn;
        wait_ready(lat);
        lat = (lat < 0) ? lat : lat + 1;
        if (b == 32'd0) begin
            // Divide-by-zero finishes within two edges of the start edge.
            check({name, " byzero latency ok"}, 64'((lat == 1) || (lat == 2)), 64'd1);
        end else begin
            check({name, " latency"}, 64'(lat), 64'd33);
        end
        check({name, " result"}, result_o, exp_res);
        @(posedge clk); #1;
        check({name, " hold ready"}, 64'(ready_o), 64'd1);
        check({name, " hold result"}, result_o, exp_res);
        release_and_check(name);
    endtask

    initial begin
        vec_t vecs[10];
        int   lat;

        vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
        vecs[3] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
        vecs[4] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
        vecs[5] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0};
        vecs[6] = '{1'b0, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  32'd1};
        vecs[7] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE};
        vecs[8] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
        vecs[9] = '{1'b0, 32'd12345,      32'd0,          32'd0,          32'd0};

        rst = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i = 32'd0;
        opdata2_i = 32'd0;
        start_i = 1'b0;
        annul_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ready", 64'(ready_o), 64'd0);
        check("reset result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
                   {vecs[i].r, vecs[i].q});
        end
        run_op("signed byzero", 1'b1, 32'h8000_0000, 32'd0, 64'd0);

        // Annul after ten iterations: back to idle, no result.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk); #1;
        check("annul ready", 64'(ready_o), 64'd0);
        check("annul result", result_o, 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        begin
            int seen = 0;
            repeat (40) begin
                @(posedge clk); #1;
                if (ready_o) seen = 1;
            end
            check("annul stays idle", 64'(seen), 64'd0);
        end
        run_op("after annul 50/5", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10});

        // Annul during the end state with start still high.
        @(negedge clk);
        opdata1_i = 32'd9;
        opdata2_i = 32'd0;
        start_i = 1'b1;
        wait_ready(lat);
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk); #1;
        check("annul end ready", 64'(ready_o), 64'd0);
        @(negedge clk);
        annul_i = 1'b0;

        // Reset in the middle of an operation, start held throughout.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i = 1'b1;
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst ready", 64'(ready_o), 64'd0);
        check("midrst result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_ready(lat);
        check("midrst restart latency", 64'(lat), 64'd33);
        check("midrst restart result", result_o, {32'd2, 32'd14});
        release_and_check("midrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
